// File: rtl/d7s_pkg.sv
// Shared constants for the seven-segment scan path: segment bit positions,
// canonical digit patterns (gfedcba), digit slot indices and accept classes.
package d7s_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_CODE_0 = 7'h3F;
    localparam logic [6:0] SEG_CODE_1 = 7'h06;
    localparam logic [6:0] SEG_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG_CODE_3 = 7'h4F;
    localparam logic [6:0] SEG_CODE_4 = 7'h66;
    localparam logic [6:0] SEG_CODE_5 = 7'h6D;
    localparam logic [6:0] SEG_CODE_6 = 7'h7D;
    localparam logic [6:0] SEG_CODE_7 = 7'h07;
    localparam logic [6:0] SEG_CODE_8 = 7'h7F;
    localparam logic [6:0] SEG_CODE_9 = 7'h6F;

    localparam int unsigned DIG_UNITS    = 0;
    localparam int unsigned DIG_TENS     = 1;
    localparam int unsigned DIG_HUNDREDS = 2;
    localparam int unsigned NUM_DIGITS   = 3;

    // What a settled scan slot turned out to be.
    typedef enum logic [1:0] {
        ACC_NONE,    // no accept this cycle, or a blanking interval
        ACC_MULTI,   // more than one digit line active
        ACC_DIGIT,   // one digit line, canonical pattern
        ACC_BADSEG   // one digit line, non-digit pattern
    } acc_kind_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/d7s_scan_decoder_if.sv
// Bundle of the scan inputs and decoded-frame outputs of d7s_scan_decoder.
interface d7s_scan_decoder_if;
    import d7s_pkg::*;

    logic [NUM_DIGITS-1:0]   transistor;
    logic [6:0]              d7sp;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic                    frame_valid;
    logic [7:0]              frame_cnt;
    logic                    err_seg;
    logic                    err_multi;

    modport master (
        output transistor, d7sp, err_clr,
        input  bcd_out, frame_valid, frame_cnt, err_seg, err_multi
    );

    modport slave (
        input  transistor, d7sp, err_clr,
        output bcd_out, frame_valid, frame_cnt, err_seg, err_multi
    );

endinterface

// File: rtl/d7s_seg_decode.sv
// Combinational seven-segment to BCD decoder; only canonical patterns are valid.
module d7s_seg_decode
    import d7s_pkg::*;
(
    input  logic [SEG_G:SEG_A] pattern,
    output logic [3:0]         digit,
    output logic               valid
);

    // Map each canonical pattern to its digit; anything else is flagged invalid.
    always_comb begin
        digit = '0;
        valid = 1'b1;
        case (pattern)
            SEG_CODE_0: digit = 4'd0;
            SEG_CODE_1: digit = 4'd1;
            SEG_CODE_2: digit = 4'd2;
            SEG_CODE_3: digit = 4'd3;
            SEG_CODE_4: digit = 4'd4;
            SEG_CODE_5: digit = 4'd5;
            SEG_CODE_6: digit = 4'd6;
            SEG_CODE_7: digit = 4'd7;
            SEG_CODE_8: digit = 4'd8;
            SEG_CODE_9: digit = 4'd9;
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/d7s_scan_decoder.sv
// Receive side of the multiplexed 3-digit display: synchronizes the digit
// select and segment lines, waits for each scan slot to settle, decodes it and
// publishes a complete {hundreds,tens,units} BCD frame once all digits are seen.
module d7s_scan_decoder
    import d7s_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    d7s_scan_decoder_if.slave   bus
);

    localparam int unsigned IN_W  = NUM_DIGITS + 7;
    localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [IN_W-1:0] POL_MASK =
        {{NUM_DIGITS{SEL_ACTIVE_LOW}}, {7{SEG_ACTIVE_LOW}}};

    logic [IN_W-1:0]                  sync1;
    logic [IN_W-1:0]                  sync2;
    logic [IN_W-1:0]                  s;
    logic [IN_W-1:0]                  s_prev;
    logic [CNT_W-1:0]                 settle_cnt;
    logic                             stable;
    logic                             accept;
    logic [NUM_DIGITS-1:0]            sel;
    logic [6:0]                       pattern;
    logic [3:0]                       dec_digit;
    logic                             dec_valid;
    acc_kind_t                        acc_kind;
    logic [NUM_DIGITS-1:0][3:0]       slot;
    logic [NUM_DIGITS-1:0][3:0]       slot_next;
    logic [NUM_DIGITS-1:0]            seen;
    logic                             frame_done;
    logic [4*NUM_DIGITS-1:0]          bcd_q;
    logic                             frame_valid_q;
    logic [7:0]                       frame_cnt_q;
    logic                             err_seg_q;
    logic                             err_multi_q;

    // Two-flop synchronizer on the raw display lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.transistor, bus.d7sp};
            sync2 <= sync1;
        end
    end

    // Polarity correction after synchronization, then split into select and segments.
    always_comb begin
        s       = sync2 ^ POL_MASK;
        sel     = s[IN_W-1 -: NUM_DIGITS];
        pattern = s[6:0];
        stable  = (s == s_prev);
        accept  = stable && (settle_cnt == CNT_W'(SETTLE - 1));
    end

    // Settle counter: restarts on any change, saturates at SETTLE so one
    // stable interval yields exactly one accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev     <= '0;
            settle_cnt <= '0;
        end else begin
            s_prev <= s;
            if (!stable) begin
                settle_cnt <= '0;
            end else if (settle_cnt != CNT_W'(SETTLE)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    d7s_seg_decode u_seg_decode (
        .pattern (pattern),
        .digit   (dec_digit),
        .valid   (dec_valid)
    );

    // Classify the accepted slot and build the slot contents including any new digit.
    always_comb begin
        acc_kind   = ACC_NONE;
        slot_next  = slot;
        frame_done = 1'b0;
        if (accept && (sel != '0)) begin
            if (!is_onehot(sel)) begin
                acc_kind = ACC_MULTI;
            end else if (dec_valid) begin
                acc_kind = ACC_DIGIT;
            end else begin
                acc_kind = ACC_BADSEG;
            end
        end
        if (acc_kind == ACC_DIGIT) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    slot_next[i] = dec_digit;
                end
            end
            frame_done = ((seen | sel) == '1);
        end
    end

    // Slot storage, frame publication and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot          <= '0;
            seen          <= '0;
            bcd_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            slot          <= slot_next;
            frame_valid_q <= frame_done;
            if (frame_done) begin
                bcd_q       <= slot_next;
                frame_cnt_q <= frame_cnt_q + 8'd1;
                seen        <= '0;
            end else if (acc_kind == ACC_DIGIT) begin
                seen <= seen | sel;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_seg_q   <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            err_seg_q   <= (acc_kind == ACC_BADSEG) | (err_seg_q & ~bus.err_clr);
            err_multi_q <= (acc_kind == ACC_MULTI) | (err_multi_q & ~bus.err_clr);
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.err_seg     = err_seg_q;
    assign bus.err_multi   = err_multi_q;

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// Directed self-checking bench for d7s_scan_decoder with SETTLE=4, active-high lines.
module tb_d7s_scan_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fv_count;
    int   fv_idx;
    int   base;

    d7s_scan_decoder_if bus ();

    d7s_scan_decoder #(
        .SETTLE         (4),
        .SEG_ACTIVE_LOW (1'b0),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which frame_valid is high, sampled just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.frame_valid === 1'b1) fv_count++;
    end

    // Drive one slot and hold it n cycles; fv_idx records the cycle frame_valid was seen.
    task automatic hold(input logic [2:0] sel, input logic [6:0] seg, input int n);
        bus.transistor = sel;
        bus.d7sp       = seg;
        fv_idx         = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #2;
            if (bus.frame_valid === 1'b1) fv_idx = i;
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.transistor = 3'b000;
        bus.d7sp       = 7'h00;
        bus.err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        hold(3'b000, 7'h00, 20);
        checks++; if (bus.bcd_out !== 12'h000) begin failures++; $display("FAIL reset_bcd: got %h expected 000", bus.bcd_out); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv: got %b expected 0", bus.frame_valid); end
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", bus.frame_cnt); end
        checks++; if (bus.err_seg !== 1'b0) begin failures++; $display("FAIL reset_err_seg: got %b expected 0", bus.err_seg); end
        checks++; if (bus.err_multi !== 1'b0) begin failures++; $display("FAIL reset_err_multi: got %b expected 0", bus.err_multi); end
        checks++; if (fv_count !== 0) begin failures++; $display("FAIL reset_fv_pulses: got %0d expected 0", fv_count); end
    endtask

    task automatic test_frame();
        int i_units, i_tens;
        hold(3'b001, 7'h66, 10); i_units = fv_idx;
        hold(3'b010, 7'h4F, 10); i_tens  = fv_idx;
        hold(3'b100, 7'h06, 10);
        checks++; if (i_units + i_tens !== 0) begin failures++; $display("FAIL frame_early: got units=%0d tens=%0d expected 0 0", i_units, i_tens); end
        checks++; if (fv_idx !== 7) begin failures++; $display("FAIL frame_latency: got %0d expected 7", fv_idx); end
        checks++; if (bus.bcd_out !== 12'h134) begin failures++; $display("FAIL frame_bcd: got %h expected 134", bus.bcd_out); end
        checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL frame_cnt: got %0d expected 1", bus.frame_cnt); end
        checks++; if (fv_count !== 1) begin failures++; $display("FAIL frame_pulses: got %0d expected 1", fv_count); end
    endtask

    task automatic test_glitch();
        base = fv_count;
        hold(3'b001, 7'h3F, 3);
        hold(3'b010, 7'h5B, 3);
        hold(3'b100, 7'h4F, 3);
        hold(3'b000, 7'h00, 10);
        checks++; if (fv_count !== base) begin failures++; $display("FAIL glitch_pulses: got %0d expected %0d", fv_count, base); end
        checks++; if (bus.bcd_out !== 12'h134) begin failures++; $display("FAIL glitch_bcd: got %h expected 134", bus.bcd_out); end
        checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL glitch_cnt: got %0d expected 1", bus.frame_cnt); end
    endtask

    task automatic test_bad_seg();
        base = fv_count;
        hold(3'b001, 7'h07, 10);
        hold(3'b010, 7'h7C, 10);
        hold(3'b100, 7'h7F, 10);
        checks++; if (bus.err_seg !== 1'b1) begin failures++; $display("FAIL badseg_flag: got %b expected 1", bus.err_seg); end
        checks++; if (fv_count !== base) begin failures++; $display("FAIL badseg_no_frame: got %0d expected %0d", fv_count, base); end
        hold(3'b010, 7'h5B, 10);
        checks++; if (bus.bcd_out !== 12'h827) begin failures++; $display("FAIL badseg_bcd: got %h expected 827", bus.bcd_out); end
        checks++; if (bus.frame_cnt !== 8'd2) begin failures++; $display("FAIL badseg_cnt: got %0d expected 2", bus.frame_cnt); end
        checks++; if (bus.err_seg !== 1'b1) begin failures++; $display("FAIL badseg_sticky: got %b expected 1", bus.err_seg); end
        bus.err_clr = 1'b1;
        @(posedge clk);
        #2;
        bus.err_clr = 1'b0;
        checks++; if (bus.err_seg !== 1'b0) begin failures++; $display("FAIL badseg_clear: got %b expected 0", bus.err_seg); end
        checks++; if (bus.err_multi !== 1'b0) begin failures++; $display("FAIL badseg_multi: got %b expected 0", bus.err_multi); end
    endtask

    task automatic test_multi();
        hold(3'b011, 7'h06, 10);
        checks++; if (bus.err_multi !== 1'b1) begin failures++; $display("FAIL multi_flag: got %b expected 1", bus.err_multi); end
        hold(3'b000, 7'h00, 10);
        hold(3'b011, 7'h06, 6);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #2;
        bus.err_clr = 1'b0;
        checks++; if (bus.err_multi !== 1'b1) begin failures++; $display("FAIL multi_set_wins: got %b expected 1", bus.err_multi); end
        hold(3'b011, 7'h06, 4);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #2;
        bus.err_clr = 1'b0;
        checks++; if (bus.err_multi !== 1'b0) begin failures++; $display("FAIL multi_clear: got %b expected 0", bus.err_multi); end
        checks++; if (bus.bcd_out !== 12'h827) begin failures++; $display("FAIL multi_bcd: got %h expected 827", bus.bcd_out); end
    endtask

    task automatic test_reset_mid_and_wrap();
        hold(3'b001, 7'h6D, 10);
        hold(3'b010, 7'h7D, 10);
        rst            = 1'b1;
        bus.transistor = 3'b100;
        bus.d7sp       = 7'h4F;
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b0;
        base = fv_count;
        hold(3'b100, 7'h4F, 10);
        checks++; if (fv_count !== base) begin failures++; $display("FAIL rstmid_no_frame: got %0d expected %0d", fv_count, base); end
        checks++; if (bus.bcd_out !== 12'h000) begin failures++; $display("FAIL rstmid_bcd: got %h expected 000", bus.bcd_out); end
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.frame_cnt); end
        // Hundreds=3 is already captured, so the first frame closes on tens as 329.
        for (int i = 0; i < 256; i++) begin
            hold(3'b001, 7'h6F, 8);
            hold(3'b010, 7'h5B, 8);
            hold(3'b100, 7'h3F, 8);
            if (i == 0) begin
                checks++; if (bus.bcd_out !== 12'h329) begin failures++; $display("FAIL wrap_first_bcd: got %h expected 329", bus.bcd_out); end
            end
            if (i == 254) begin
                checks++; if (bus.frame_cnt !== 8'd255) begin failures++; $display("FAIL wrap_cnt_255: got %0d expected 255", bus.frame_cnt); end
            end
        end
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt_0: got %0d expected 0", bus.frame_cnt); end
        checks++; if (bus.bcd_out !== 12'h029) begin failures++; $display("FAIL wrap_bcd: got %h expected 029", bus.bcd_out); end
        checks++; if (fv_count - base !== 256) begin failures++; $display("FAIL wrap_pulses: got %0d expected 256", fv_count - base); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fv_count = 0;
        fv_idx   = 0;
        base     = 0;
        test_reset();
        test_frame();
        test_glitch();
        test_bad_seg();
        test_multi();
        test_reset_mid_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
